// File: rtl/scan_job_scheduler_if.sv
// Job request/grant bus between the two scan requesters, the scheduler and the pseudo-SPI engine.
// Requesters and the engine sit on the master side; the scheduler is the slave.

interface scan_job_scheduler_if #(
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8
);
  logic                         req0;
  logic                         req1;
  logic [MEMORY_ADDR_WIDTH-1:0] addr0;
  logic [MEMORY_ADDR_WIDTH-1:0] addr1;
  logic [RESERVED_DATA_LEN-1:0] len0;
  logic [RESERVED_DATA_LEN-1:0] len1;
  logic                         ack0;
  logic                         ack1;
  logic                         done0;
  logic                         done1;
  logic                         err0;
  logic                         err1;
  logic                         BGN;
  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN;
  logic [RESERVED_DATA_LEN-1:0] DATA_LEN;
  logic                         spi_is_done;
  logic                         busy;
  logic                         grant_id;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, spi_is_done,
    output ack0, ack1, done0, done1, err0, err1, BGN, ADDR_BGN, DATA_LEN, busy, grant_id
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, spi_is_done,
    input  ack0, ack1, done0, done1, err0, err1, BGN, ADDR_BGN, DATA_LEN, busy, grant_id
  );
endinterface

// File: rtl/scan_job_scheduler.sv
// Round-robin two-requester job scheduler driving the pseudo-SPI scan engine.
// Optional BUSY timeout with abort is enabled by defining SCAN_SCHED_TIMEOUT_EN.

module scan_job_scheduler #(
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned RESERVED_DATA_LEN = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 4096
) (
  input logic                 CLK,
  input logic                 rst_n,
  scan_job_scheduler_if.slave bus
);

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $fatal(1, "TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef SCAN_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {StIdle, StGrant, StBusy, StFinish, StCool, StAbort} state_e;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [2:0] {StIdle, StGrant, StBusy, StFinish, StCool} state_e;
`endif

  state_e                       state_q, state_d;
  logic                         last_grant_q, last_grant_d;
  logic                         grant_id_q, grant_id_d;
  logic [1:0]                   ack_q, ack_d;
  logic [1:0]                   done_q, done_d;
  logic [1:0]                   err_q, err_d;
  logic                         bgn_q, bgn_d;
  logic                         busy_q, busy_d;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RESERVED_DATA_LEN-1:0] len_q, len_d;
  logic                         win;
`ifdef SCAN_SCHED_TIMEOUT_EN
  logic [15:0]                  tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ack_d        = 2'b00;
    done_d       = 2'b00;
    err_d        = 2'b00;
    bgn_d        = 1'b0;
    addr_d       = addr_q;
    len_d        = len_q;
`ifdef SCAN_SCHED_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif
    // On a tie the port that did not win last time is served.
    win = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;

    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          state_d      = StGrant;
          ack_d[win]   = 1'b1;
          addr_d       = win ? bus.addr1 : bus.addr0;
          len_d        = win ? bus.len1 : bus.len0;
          grant_id_d   = win;
          last_grant_d = win;
        end
      end
      StGrant: begin
        if (len_q == '0) begin
          err_d[grant_id_q] = 1'b1;
          state_d           = StIdle;
        end else begin
          bgn_d   = 1'b1;
          state_d = StBusy;
`ifdef SCAN_SCHED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StBusy: begin
        if (bus.spi_is_done) begin
          done_d[grant_id_q] = 1'b1;
          state_d            = StFinish;
        end else begin
          bgn_d = 1'b1;
`ifdef SCAN_SCHED_TIMEOUT_EN
          if (tmo_q == TmoLast) begin
            bgn_d             = 1'b0;
            err_d[grant_id_q] = 1'b1;
            state_d           = StAbort;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`endif
        end
      end
      StFinish: begin
        state_d = StCool;
      end
      StCool: begin
        // Never restart the engine while its done level is still up.
        if (!bus.spi_is_done) begin
          state_d = StIdle;
        end
      end
`ifdef SCAN_SCHED_TIMEOUT_EN
      StAbort: begin
        state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      ack_q        <= 2'b00;
      done_q       <= 2'b00;
      err_q        <= 2'b00;
      bgn_q        <= 1'b0;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      bgn_q        <= bgn_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
    end
  end

`ifdef SCAN_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign bus.ack0     = ack_q[0];
  assign bus.ack1     = ack_q[1];
  assign bus.done0    = done_q[0];
  assign bus.done1    = done_q[1];
  assign bus.err0     = err_q[0];
  assign bus.err1     = err_q[1];
  assign bus.BGN      = bgn_q;
  assign bus.ADDR_BGN = addr_q;
  assign bus.DATA_LEN = len_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_scan_job_scheduler.sv
// Self-checking bench for scan_job_scheduler: directed steps plus random jobs checked against
// a job-level model (round-robin rule, documented cycle timing, engine handshake).

module tb_scan_job_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Job-level reference model state.
  int         last_g;
  bit         pend [2];
  logic [8:0] p_addr [2];
  logic [7:0] p_len [2];

  scan_job_scheduler_if #(.MEMORY_ADDR_WIDTH(9), .RESERVED_DATA_LEN(8)) bus ();

  scan_job_scheduler #(
    .MEMORY_ADDR_WIDTH(9),
    .RESERVED_DATA_LEN(8),
    .TIMEOUT_CYCLES   (16)
  ) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [1:0] ack_v, done_v, err_v;
  assign ack_v  = {bus.ack1, bus.ack0};
  assign done_v = {bus.done1, bus.done0};
  assign err_v  = {bus.err1, bus.err0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_len();
    if ($urandom_range(0, 4) == 0) return 8'd0;
    return 8'($urandom_range(1, 255));
  endfunction

  task automatic post(input int p, input logic [8:0] a, input logic [7:0] l);
    pend[p]   = 1'b1;
    p_addr[p] = a;
    p_len[p]  = l;
    if (p == 0) begin
      bus.req0 = 1'b1; bus.addr0 = a; bus.len0 = l;
    end else begin
      bus.req1 = 1'b1; bus.addr1 = a; bus.len1 = l;
    end
  endtask

  task automatic drop(input int p);
    pend[p] = 1'b0;
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ack"}, 32'(ack_v), 32'd0);
    chk({pfx, "_done"}, 32'(done_v), 32'd0);
    chk({pfx, "_err"}, 32'(err_v), 32'd0);
    chk({pfx, "_bgn"}, 32'(bus.BGN), 32'd0);
    chk({pfx, "_addr"}, 32'(bus.ADDR_BGN), 32'd0);
    chk({pfx, "_len"}, 32'(bus.DATA_LEN), 32'd0);
    chk({pfx, "_busy"}, 32'(bus.busy), 32'd0);
    chk({pfx, "_gid"}, 32'(bus.grant_id), 32'd0);
  endtask

  // Called in an IDLE cycle with at least one job pending; returns in the next IDLE cycle.
  task automatic serve(input int lat, input int hold, input bit rehold);
    int w, o;
    logic [8:0] ea;
    logic [7:0] el;
    if (pend[0] && pend[1]) w = 1 - last_g;
    else                    w = pend[1] ? 1 : 0;
    o      = 1 - w;
    last_g = w;
    ea     = p_addr[w];
    el     = p_len[w];
    tick();
    chk("ack_win", 32'(ack_v[w]), 32'd1);
    chk("ack_other", 32'(ack_v[o]), 32'd0);
    chk("grant_id", 32'(bus.grant_id), 32'(w));
    chk("addr_bgn", 32'(bus.ADDR_BGN), 32'(ea));
    chk("data_len", 32'(bus.DATA_LEN), 32'(el));
    chk("busy_grant", 32'(bus.busy), 32'd1);
    chk("bgn_grant", 32'(bus.BGN), 32'd0);
    if (rehold) post(w, 9'($urandom), rand_len());
    else        drop(w);
    if (el == 8'd0) begin
      tick();
      chk("err_zero", 32'(err_v), 32'(2'b01 << w));
      chk("bgn_zero", 32'(bus.BGN), 32'd0);
      chk("busy_zero", 32'(bus.busy), 32'd0);
      chk("done_zero", 32'(done_v), 32'd0);
      return;
    end
    tick();
    chk("bgn_on", 32'(bus.BGN), 32'd1);
    chk("ack_busy", 32'(ack_v), 32'd0);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("bgn_hold", 32'(bus.BGN), 32'd1);
      chk("addr_hold", 32'(bus.ADDR_BGN), 32'(ea));
    end
    bus.spi_is_done = 1'b1;
    tick();
    chk("done_pulse", 32'(done_v), 32'(2'b01 << w));
    chk("bgn_off", 32'(bus.BGN), 32'd0);
    chk("err_none", 32'(err_v), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("cool_ack", 32'(ack_v), 32'd0);
      chk("cool_busy", 32'(bus.busy), 32'd1);
      chk("cool_done", 32'(done_v), 32'd0);
    end
    bus.spi_is_done = 1'b0;
    if (hold == 0) begin
      tick();
      chk("cool_busy0", 32'(bus.busy), 32'd1);
    end
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("addr_kept", 32'(bus.ADDR_BGN), 32'(ea));
    chk("len_kept", 32'(bus.DATA_LEN), 32'(el));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_g = 1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.len0 = '0;   bus.len1 = '0;
    bus.spi_is_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Tie from reset: port 0 first, then port 1.
    post(0, 9'h0A5, 8'd3);
    post(1, 9'h13C, 8'd1);
    serve(1, 0, 1'b0);
    serve(2, 1, 1'b0);

    // Single job with address wrap-around value.
    post(0, 9'h1FF, 8'd2);
    serve(3, 0, 1'b0);

    // Zero length on port 1.
    post(1, 9'h044, 8'd0);
    serve(0, 0, 1'b0);

    // Done level held 5 extra cycles while port 1 waits.
    post(0, 9'h010, 8'd4);
    post(1, 9'h020, 8'd5);
    serve(1, 5, 1'b0);
    serve(0, 0, 1'b0);

    // Both held high: grants alternate.
    post(0, 9'h100, 8'd1);
    post(1, 9'h101, 8'd1);
    for (int i = 0; i < 4; i++) serve(0, 0, 1'b1);
    while (pend[0] || pend[1]) serve(0, 0, 1'b0);

    // Random jobs.
    for (int it = 0; it < 40; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) post(p, 9'($urandom), rand_len());
      end
      if (!pend[0] && !pend[1]) post(int'($urandom_range(0, 1)), 9'($urandom), rand_len());
      serve(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
    end
    while (pend[0] || pend[1]) serve(0, 0, 1'b0);

    // Engine never answers.
    post(0, 9'h0F0, 8'd3);
    tick();
    chk("stuck_ack", 32'(bus.ack0), 32'd1);
    drop(0);
    last_g = 0;
    tick();
    chk("stuck_bgn1", 32'(bus.BGN), 32'd1);
`ifdef SCAN_SCHED_TIMEOUT_EN
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("tmo_bgn", 32'(bus.BGN), 32'd1);
    end
    tick();
    chk("tmo_err", 32'(err_v), 32'd1);
    chk("tmo_bgn_off", 32'(bus.BGN), 32'd0);
    chk("tmo_done", 32'(done_v), 32'd0);
    tick();
    chk("tmo_idle", 32'(bus.busy), 32'd0);
    chk("tmo_err_end", 32'(err_v), 32'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      chk("stuck_bgn", 32'(bus.BGN), 32'd1);
    end
    bus.spi_is_done = 1'b1;
    tick();
    chk("stuck_done", 32'(done_v), 32'd1);
    bus.spi_is_done = 1'b0;
    tick();
    tick();
    chk("stuck_idle", 32'(bus.busy), 32'd0);
`endif

    // Reset while BUSY.
    post(1, 9'h155, 8'd5);
    tick();
    chk("rb_ack", 32'(bus.ack1), 32'd1);
    drop(1);
    tick();
    tick();
    chk("rb_bgn", 32'(bus.BGN), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("rb_async_bgn", 32'(bus.BGN), 32'd0);
    chk("rb_async_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk_reset_vals("rb");
    rst_n = 1'b1;
    last_g = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rb_no_done", 32'(done_v), 32'd0);
      chk("rb_no_err", 32'(err_v), 32'd0);
      chk("rb_bgn_low", 32'(bus.BGN), 32'd0);
    end

    // Tie after reset goes to port 0 again.
    post(0, 9'h077, 8'd2);
    post(1, 9'h088, 8'd2);
    serve(1, 0, 1'b0);
    serve(1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
